c_fetch_realign: RTL and testbench

//  Halfword-granular fetch realignment buffer between instruction memory and the RVC decompressor.

---
 rtl/c_fetch_realign_pkg.sv | 25 ++
 rtl/c_hw_fifo.sv | 72 +++++++
 rtl/c_fetch_realign.sv | 109 ++++++++++
 tb/tb_c_fetch_realign.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c_fetch_realign_pkg.sv
// Shared definitions for the fetch realignment buffer: RVC quadrant codes,
// the canonical NOP encoding and the presented-instruction record.
package c_fetch_realign_pkg;

    localparam logic [1:0]  RVC_C0     = 2'b00;
    localparam logic [1:0]  RVC_C1     = 2'b01;
    localparam logic [1:0]  RVC_C2     = 2'b10;
    localparam logic [1:0]  RVC_UNCOMP = 2'b11;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    // Instruction as presented to the decoder; carries PCs up to 32 bits.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
        logic        zero;
    } realign_inst_t;

    // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
    function automatic logic is_comp(input logic [15:0] hw);
        return hw[1:0] != RVC_UNCOMP;
    endfunction

endpackage

// File: rtl/c_hw_fifo.sv
// Circular halfword store: writes up to NHW halfwords per cycle (skipping a
// leading run), peeks the two oldest entries and pops one or two at a time.
module c_hw_fifo
    import c_fetch_realign_pkg::*;
#(
    parameter  int DEPTH_HW = 8,
    parameter  int NHW      = 2,
    localparam int PW       = $clog2(DEPTH_HW),
    localparam int CW       = PW + 1,
    localparam int SKW      = (NHW > 1) ? $clog2(NHW) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [SKW-1:0]     wr_skip,
    input  logic [NHW*16-1:0]  wr_data,
    input  logic               pop_en,
    input  logic               pop_two,
    output logic [15:0]        hw0,
    output logic [15:0]        hw1,
    output logic [CW-1:0]      count
);

    logic [15:0]   mem [DEPTH_HW];
    logic [15:0]   wr_hw [NHW];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] wr_n;
    logic [CW-1:0] pop_n;

    for (genvar gi = 0; gi < NHW; gi++) begin : g_unpack
        assign wr_hw[gi] = wr_data[gi*16 +: 16];
    end

    assign wr_n  = wr_en  ? (CW'(NHW) - CW'(wr_skip)) : '0;
    assign pop_n = pop_en ? (pop_two ? CW'(2) : CW'(1)) : '0;

    // Pointer and occupancy bookkeeping; flush empties the store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + PW'(pop_n);
            wr_ptr_reg <= wr_ptr_reg + PW'(wr_n);
            count_reg  <= count_reg + wr_n - pop_n;
        end
    end

    // Storage write: halfwords skip..NHW-1 land contiguously from wr_ptr.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            for (int i = 0; i < NHW; i++) begin
                if (i >= int'(wr_skip)) begin
                    mem[wr_ptr_reg + PW'(i - int'(wr_skip))] <= wr_hw[i];
                end
            end
        end
    end

    assign hw0   = mem[rd_ptr_reg];
    assign hw1   = mem[rd_ptr_reg + PW'(1)];
    assign count = count_reg;

endmodule

// File: rtl/c_fetch_realign.sv
// Fetch realignment buffer: queues fetch halfwords and presents one 16- or
// 32-bit instruction per handshake with its exact PC and compressed flag.
module c_fetch_realign
    import c_fetch_realign_pkg::*;
#(
    parameter int FETCH_W  = 32,
    parameter int DEPTH_HW = 8,
    parameter int PC_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_valid_i,
    output logic               fetch_ready_o,
    input  logic [FETCH_W-1:0] fetch_data_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_o,
    output logic [PC_W-1:0]    inst_pc_o,
    output logic               inst_comp_o,
    output logic               inst_zero_o
);

    localparam int NHW = FETCH_W / 16;
    localparam int PW  = $clog2(DEPTH_HW);
    localparam int CW  = PW + 1;
    localparam int SKW = (NHW > 1) ? $clog2(NHW) : 1;

    logic [SKW-1:0]  skip_reg;
    logic [PC_W-1:0] head_pc_reg;
    logic [15:0]     hw0;
    logic [15:0]     hw1;
    logic [CW-1:0]   count;
    logic            head_comp;
    logic            empty;
    logic            enq;
    logic            deq;
    realign_inst_t   head;
    logic            unused_pc_bit;

    assign unused_pc_bit = redirect_pc_i[0];

    c_hw_fifo #(
        .DEPTH_HW (DEPTH_HW),
        .NHW      (NHW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_i),
        .wr_en    (enq),
        .wr_skip  (skip_reg),
        .wr_data  (fetch_data_i),
        .pop_en   (deq),
        .pop_two  (!head_comp),
        .hw0      (hw0),
        .hw1      (hw1),
        .count    (count)
    );

    // Room for a whole fetch word, judged on current occupancy only.
    assign fetch_ready_o = (CW'(DEPTH_HW) - count) >= CW'(NHW);

    assign head_comp    = is_comp(hw0);
    assign empty        = (count == '0);
    assign inst_valid_o = head_comp ? (count >= CW'(1)) : (count >= CW'(2));

    assign enq = fetch_valid_i && fetch_ready_o && !redirect_i;
    assign deq = inst_valid_o && inst_ready_i && !redirect_i;

    // Head decode; an empty buffer presents zeros so nothing stale leaks out.
    always_comb begin
        head      = '0;
        head.pc   = 32'(head_pc_reg);
        if (!empty) begin
            head.inst = head_comp ? {16'h0000, hw0} : {hw1, hw0};
            head.comp = head_comp;
            head.zero = head_comp && (hw0 == 16'h0000);
        end
    end

    assign inst_o      = head.inst;
    assign inst_pc_o   = PC_W'(head.pc);
    assign inst_comp_o = head.comp;
    assign inst_zero_o = head.zero;

    // Skip count drops the halfwords below a misaligned redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_reg <= '0;
        end else if (redirect_i) begin
            skip_reg <= redirect_pc_i[SKW:1];
        end else if (enq) begin
            skip_reg <= '0;
        end
    end

    // Head PC follows redirects and advances by the consumed instruction size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_pc_reg <= '0;
        end else if (redirect_i) begin
            head_pc_reg <= {redirect_pc_i[PC_W-1:1], 1'b0};
        end else if (deq) begin
            head_pc_reg <= head_pc_reg + (head_comp ? PC_W'(2) : PC_W'(4));
        end
    end

endmodule

// File: tb/tb_c_fetch_realign.sv
// Self-checking bench for c_fetch_realign (FETCH_W=64) against a halfword-queue model.
module tb_c_fetch_realign;

    localparam int FETCH_W  = 64;
    localparam int DEPTH_HW = 8;
    localparam int PC_W     = 32;
    localparam int NHW      = FETCH_W / 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               fetch_valid_i = 1'b0;
    logic               fetch_ready_o;
    logic [FETCH_W-1:0] fetch_data_i = '0;
    logic               redirect_i = 1'b0;
    logic [PC_W-1:0]    redirect_pc_i = '0;
    logic               inst_valid_o;
    logic               inst_ready_i = 1'b0;
    logic [31:0]        inst_o;
    logic [PC_W-1:0]    inst_pc_o;
    logic               inst_comp_o;
    logic               inst_zero_o;

    c_fetch_realign #(
        .FETCH_W  (FETCH_W),
        .DEPTH_HW (DEPTH_HW),
        .PC_W     (PC_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_data_i  (fetch_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_comp_o   (inst_comp_o),
        .inst_zero_o   (inst_zero_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered halfwords, head PC and pending skip.
    logic [15:0]     mq[$];
    logic [PC_W-1:0] m_pc = '0;
    int              m_skip = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_comp();
        if (mq.size() == 0) return 1'b0;
        return mq[0][1:0] != 2'b11;
    endfunction

    function automatic logic m_valid();
        if (mq.size() == 0) return 1'b0;
        return m_comp() ? 1'b1 : (mq.size() >= 2);
    endfunction

    function automatic logic m_ready();
        return (DEPTH_HW - mq.size()) >= NHW;
    endfunction

    function automatic logic [31:0] m_inst();
        if (m_comp()) return {16'h0000, mq[0]};
        return {mq[1], mq[0]};
    endfunction

    task automatic compare_all();
        check("ready", fetch_ready_o, m_ready());
        check("valid", inst_valid_o, m_valid());
        check("pc", inst_pc_o, m_pc);
        if (m_valid()) begin
            check("inst", inst_o, m_inst());
            check("comp", inst_comp_o, m_comp());
            check("zero", inst_zero_o, m_comp() && (mq[0] == 16'h0000));
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model,
    // then check the DUT at the following negedge.
    task automatic step(input logic fv, input logic [FETCH_W-1:0] fd, input logic rd,
                        input logic [PC_W-1:0] rpc, input logic ir);
        logic acc;
        logic dq;
        logic comp;
        fetch_valid_i = fv;
        fetch_data_i  = fd;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        inst_ready_i  = ir;
        acc  = fv && m_ready() && !rd;
        dq   = m_valid() && ir && !rd;
        comp = m_comp();
        if (rd) begin
            mq.delete();
            m_pc   = {rpc[PC_W-1:1], 1'b0};
            m_skip = int'(rpc[$clog2(NHW):1]);
        end else begin
            if (dq) begin
                $display("deq pc=%08h inst=%08h comp=%0d", m_pc, m_inst(), comp);
                void'(mq.pop_front());
                if (!comp) void'(mq.pop_front());
                m_pc = m_pc + (comp ? 32'd2 : 32'd4);
            end
            if (acc) begin
                for (int i = m_skip; i < NHW; i++) mq.push_back(fd[i*16 +: 16]);
                m_skip = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] r;
        int          k;
        r = 16'($urandom);
        k = int'($urandom_range(0, 9));
        if (k == 0) r = 16'h0000;
        else if (k <= 4) r[1:0] = 2'b11;
        else if (r[1:0] == 2'b11) r[1:0] = 2'b01;
        return r;
    endfunction

    function automatic logic [FETCH_W-1:0] rand_word();
        logic [FETCH_W-1:0] w;
        for (int i = 0; i < NHW; i++) w[i*16 +: 16] = rand_hw();
        return w;
    endfunction

    task automatic idle(input logic ir);
        step(1'b0, '0, 1'b0, '0, ir);
    endtask

    task automatic fetch(input logic [FETCH_W-1:0] fd, input logic ir);
        step(1'b1, fd, 1'b0, '0, ir);
    endtask

    task automatic redirect(input logic [PC_W-1:0] rpc);
        step(1'b0, '0, 1'b1, rpc, 1'b0);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_pc", inst_pc_o, 32'h0);
        check("rst_comp", inst_comp_o, 1'b0);
        check("rst_zero", inst_zero_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", fetch_ready_o, 1'b1);
        compare_all();

        // Directed: compressed pair followed by an aligned 32-bit NOP
        redirect(32'h0);
        fetch(64'h0000_0013_00A2_4581, 1'b0);
        check("d1_inst0", inst_o, 32'h0000_4581);
        check("d1_comp0", inst_comp_o, 1'b1);
        idle(1'b1);
        check("d1_inst1", inst_o, 32'h0000_00A2);
        check("d1_pc1", inst_pc_o, 32'h2);
        idle(1'b1);
        check("d1_inst2", inst_o, 32'h0000_0013);
        check("d1_pc2", inst_pc_o, 32'h4);
        check("d1_comp2", inst_comp_o, 1'b0);
        idle(1'b1);

        // Directed: 32-bit instruction straddling two fetch words
        redirect(32'h6);
        fetch(64'h0513_1111_2222_3333, 1'b1);
        check("d2_wait", inst_valid_o, 1'b0);
        fetch(64'h4444_5555_6666_0050, 1'b1);
        check("d2_valid", inst_valid_o, 1'b1);
        check("d2_inst", inst_o, 32'h0050_0513);
        check("d2_pc", inst_pc_o, 32'h6);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Directed: backpressure then drain
        for (int i = 0; i < 5; i++) fetch(rand_word(), 1'b0);
        check("d3_full", fetch_ready_o, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b1);

        // Directed: redirect colliding with fetch and dequeue
        fetch(rand_word(), 1'b0);
        step(1'b1, rand_word(), 1'b1, 32'h106, 1'b1);
        check("d4_valid", inst_valid_o, 1'b0);
        fetch(64'h1111_2222_3333_4444, 1'b0);
        check("d4_inst", inst_o, 32'h0000_1111);
        check("d4_pc", inst_pc_o, 32'h106);
        idle(1'b1);

        // Directed: illegal all-zero halfword
        redirect(32'h0);
        fetch(64'h0000_0001_0001_0000, 1'b0);
        check("d5_zero", inst_zero_o, 1'b1);
        check("d5_comp", inst_comp_o, 1'b1);
        idle(1'b1);
        check("d5_pc", inst_pc_o, 32'h2);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Random traffic with phases of heavy and light backpressure
        for (int c = 0; c < 1500; c++) begin
            int          pr;
            logic        rd;
            logic [31:0] rpc;
            pr  = (c / 100) % 2 == 0 ? 80 : 30;
            rd  = ($urandom_range(0, 99) < 3);
            rpc = $urandom_range(0, 32'hFFFF) & 32'hFFFF_FFFE;
            step($urandom_range(0, 99) < 60, rand_word(), rd, rpc,
                 $urandom_range(0, 99) < pr);
        end

        // Asynchronous reset in the middle of a stream
        fetch(rand_word(), 1'b0);
        fetch(rand_word(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", inst_valid_o, 1'b0);
        check("ar_inst", inst_o, 32'h0);
        check("ar_pc", inst_pc_o, 32'h0);
        check("ar_comp", inst_comp_o, 1'b0);
        check("ar_zero", inst_zero_o, 1'b0);
        mq.delete();
        m_pc   = '0;
        m_skip = 0;
        fetch_valid_i = 1'b0;
        inst_ready_i  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_ready", fetch_ready_o, 1'b1);
        compare_all();
        fetch(rand_word(), 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
